// File: rtl/pc_fetch_queue.sv
// Program counter and instruction fetch with a small decoupling queue.
// Ports: clk/reset (async active-low); imem_* memory handshake with one
//   request outstanding at most; jump_*/branch_* redirects (jump wins);
//   if_valid/if_instr/if_pc/if_ready present the queue head to decode;
//   queue_count reports occupied entries.
module pc_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                STEP     = 4,
    parameter int                DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       jump_valid,
    input  logic [ADDR_W-1:0]          jump_target,
    input  logic                       branch_valid,
    input  logic [ADDR_W-1:0]          branch_pc,
    input  logic [ADDR_W-1:0]          branch_offset,
    output logic                       if_valid,
    output logic [DATA_W-1:0]          if_instr,
    output logic [ADDR_W-1:0]          if_pc,
    input  logic                       if_ready,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int                PW      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
    localparam logic [PW:0]       DEPTH_C = (PW+1)'(DEPTH);

    // KILL: the outstanding request was issued on a path that has since
    // been redirected, so its response must be dropped.
    typedef enum logic {RUN, KILL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;

    logic [DATA_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc    [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              ack;
    logic              push;
    logic              pop;
    logic [PW:0]       count_next;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic              can_issue;

    always_comb begin
        redirect = jump_valid | branch_valid;
        target   = jump_valid ? jump_target
                              : branch_pc + STEP_A + branch_offset;
        ack      = imem_ack & imem_req;
        push     = ack & (state == RUN) & ~redirect;
        pop      = if_valid & if_ready;

        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + (PW+1)'(push) - (PW+1)'(pop);
        end

        if (redirect) begin
            fetch_pc_next = target;
        end else if (push) begin
            fetch_pc_next = imem_addr + STEP_A;
        end else begin
            fetch_pc_next = fetch_pc;
        end

        can_issue = count_next < DEPTH_C;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            count    <= count_next;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end

            unique case (state)
                RUN: begin
                    if (imem_req && !ack) begin
                        // Request still in flight: hold it; a redirect
                        // now means its data belongs to a stale path.
                        if (redirect) state <= KILL;
                    end else begin
                        imem_req  <= can_issue;
                        imem_addr <= fetch_pc_next;
                    end
                end
                KILL: begin
                    if (ack) begin
                        state     <= RUN;
                        imem_req  <= can_issue;
                        imem_addr <= fetch_pc_next;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= imem_addr;
        end
    end

    always_comb begin
        if_valid    = count != '0;
        if_instr    = if_valid ? q_instr[rd_ptr] : '0;
        if_pc       = if_valid ? q_pc[rd_ptr] : '0;
        queue_count = count;
    end

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue: a latency-programmable memory model
// answers fetches with ~addr; a scoreboard of expected PCs checks pops.
module tb_pc_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_valid;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [2:0]  queue_count;

    pc_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .STEP(4), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .branch_valid(branch_valid), .branch_pc(branch_pc),
        .branch_offset(branch_offset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .queue_count(queue_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0 = 0;
    int lat = 0;
    int lat_cnt = 0;
    int npop = 0;
    int first_pop = 0;
    int last_pop = 0;
    logic [31:0] sb[$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: ack arrives after lat extra cycles of a held request.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            imem_ack = 0;
            lat_cnt = 0;
        end else begin
            imem_ack = 0;
            if (imem_req) begin
                if (lat_cnt >= lat) begin
                    imem_ack = 1;
                    imem_rdata = ~imem_addr;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Scoreboard: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && if_valid && if_ready) begin
            chk("pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("pop_pc", if_pc, e);
                chk("pop_instr", if_instr, ~e);
                if (npop == 0) first_pop = cyc;
                last_pop = cyc;
                npop++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 0;
        sb.delete();
        tick(2);
        reset = 1;
        c0 = cyc;
        npop = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 0;
        if_ready = 0;
        jump_valid = 0;
        jump_target = 0;
        branch_valid = 0;
        branch_pc = 0;
        branch_offset = 0;
        imem_rdata = 0;
        #3;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_count", 32'(queue_count), 32'd0);

        // Streaming at one instruction per cycle.
        lat = 0;
        if_ready = 1;
        do_reset();
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        tick(1);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        wait_drain("stream_drain");
        if_ready = 0;
        chk("stream_first", 32'(first_pop - c0), 32'd2);
        chk("stream_span", 32'(last_pop - first_pop), 32'd7);

        // Fill to DEPTH, then release.
        do_reset();
        tick(8);
        chk("full_count", 32'(queue_count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        if_ready = 1;
        tick(1);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h10);
        wait_drain("resume_drain");
        if_ready = 0;

        // Jump while a slow fetch is outstanding.
        lat = 2;
        if_ready = 1;
        do_reset();
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        begin
            int n;
            n = 0;
            while (!(imem_req && imem_addr == 32'h8) && n < 60) begin
                tick(1);
                n++;
            end
        end
        chk("see_req8", imem_addr, 32'h8);
        jump_valid = 1;
        jump_target = 32'h100;
        tick(1);
        jump_valid = 0;
        chk("kill_req", 32'(imem_req), 32'd1);
        chk("kill_addr", imem_addr, 32'h8);
        chk("kill_count", 32'(queue_count), 32'd0);
        tick(1);
        chk("kill_hold", imem_addr, 32'h8);
        tick(1);
        chk("kill_next_req", 32'(imem_req), 32'd1);
        chk("kill_next_addr", imem_addr, 32'h100);
        chk("kill_empty", 32'(queue_count), 32'd0);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        wait_drain("kill_drain");
        if_ready = 0;

        // Jump beats branch; then branch alone with a same-cycle ack.
        lat = 0;
        do_reset();
        tick(8);
        chk("idle_req", 32'(imem_req), 32'd0);
        jump_valid = 1;
        jump_target = 32'h200;
        branch_valid = 1;
        branch_pc = 32'h40;
        branch_offset = 32'h10;
        tick(1);
        jump_valid = 0;
        chk("prio_req", 32'(imem_req), 32'd1);
        chk("prio_addr", imem_addr, 32'h200);
        chk("prio_count", 32'(queue_count), 32'd0);
        tick(1);
        branch_valid = 0;
        chk("br_addr", imem_addr, 32'h54);
        chk("br_count", 32'(queue_count), 32'd0);
        sb.push_back(32'h54);
        sb.push_back(32'h58);
        if_ready = 1;
        wait_drain("br_drain");
        if_ready = 0;

        // Branch target wraps around the address space.
        branch_valid = 1;
        branch_pc = 32'hFFFF_FFF8;
        branch_offset = 32'h8;
        tick(1);
        branch_valid = 0;
        chk("wrap_addr", imem_addr, 32'h4);
        chk("wrap_count", 32'(queue_count), 32'd0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        if_ready = 1;
        wait_drain("wrap_drain");
        if_ready = 0;

        // Asynchronous reset with 3 queued entries and a live request.
        do_reset();
        begin
            int n;
            n = 0;
            while (!(queue_count == 3 && imem_req) && n < 60) begin
                tick(1);
                n++;
            end
        end
        chk("pre_count", 32'(queue_count), 32'd3);
        chk("pre_instr", if_instr, 32'hFFFF_FFFF);
        reset = 0;
        sb.delete();
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_instr", if_instr, 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_count", 32'(queue_count), 32'd0);
        tick(1);
        reset = 1;
        tick(1);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        if_ready = 1;
        wait_drain("restart_drain");
        if_ready = 0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_queue.md
# pc_fetch_queue

Parametrised program-counter and instruction-fetch stage with a decoupling instruction queue. Generates sequential fetch addresses, applies jump/branch redirects with jump priority, handles a variable-latency instruction-memory handshake with one outstanding request, and presents fetched instructions with their PCs to decode over a valid/ready interface. It replaces the inline PC register of the single-issue core top and sits between instruction memory and the decode stage.

## Interface
- ADDR_W, 32, width of PC and memory address
- DATA_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- STEP, 4, byte increment per sequential instruction
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  ADDR_W  fetch address, stable while imem_req high
- imem_ack  in  1  one-cycle response strobe; valid only while imem_req high
- imem_rdata  in  DATA_W  instruction, valid with imem_ack
- jump_valid  in  1  absolute redirect this cycle
- jump_target  in  ADDR_W  absolute target
- branch_valid  in  1  taken-branch redirect this cycle
- branch_pc  in  ADDR_W  PC of the branch instruction
- branch_offset  in  ADDR_W  signed byte offset
- if_valid  out  1  queue head valid
- if_instr  out  DATA_W  queue head instruction
- if_pc  out  ADDR_W  queue head PC
- if_ready  in  1  decode accepts head
- queue_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc, imem_req/imem_addr, circular queue (rd/wr pointers, count), state.
- States: RUN (normal fetch), KILL (outstanding request belongs to a stale path).
- Issue rule (RUN): imem_req next = (count_next + 0) < DEPTH, where count_next includes this cycle's push/pop/flush; imem_addr = fetch_pc. No new request while one is outstanding.
- Ack in RUN without redirect: push {imem_rdata, imem_addr}; fetch_pc ← imem_addr + STEP (mod 2^ADDR_W).
- Pop: if_valid && if_ready removes head. Push and pop same cycle: count unchanged. Push when count == DEPTH cannot occur (issue rule); pop when empty is ignored.
- Redirect: jump_valid wins over branch_valid. Target = jump_target, or branch_pc + STEP + branch_offset, truncated to ADDR_W (wrap-around allowed).
- On redirect: queue flushed (count 0, pointers 0) at the edge; fetch_pc ← target. A pop in the same cycle is still considered accepted; an ack in the same cycle is discarded.
- Redirect with request outstanding and no ack this cycle: go KILL; imem_req and imem_addr stay unchanged until ack; that response is discarded; then RUN, next request at the new target.
- Redirect while in KILL: fetch_pc updated to the newest target, queue stays empty, stay KILL.
- Redirect with no request outstanding: stay RUN; next cycle imem_req high at target.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, queue_count 0, fetch_pc RESET_PC, state RUN.
- First cycle after reset release: imem_req 1, imem_addr RESET_PC.
- Ack at cycle N: entry visible on if_valid/if_instr/if_pc at N+1; next request at N+1 if space.
- Memory acking in the request cycle: one instruction per cycle sustained.
- Redirect at cycle N (no outstanding): imem_addr = target at N+1; first target instruction at if_valid ≥ N+2.
- Queue full with if_ready low: imem_req low; first pop re-enables imem_req next cycle.
- Reset asserted mid-request: imem_req drops asynchronously; memory is reset by the same signal.

## Test plan
- Reset, ack every cycle, if_ready 1: if_pc sequence 0x0,0x4,0x8,…; one instruction per cycle from cycle 2.
- if_ready 0, DEPTH 4: queue_count reaches 4, imem_req low; raise if_ready: 4 pops in order, fetch resumes at 0x10.
- Ack 3-cycle latency, jump_valid to 0x100 while request outstanding at 0x8: state KILL, 0x8 data discarded, next imem_addr 0x100, queue empty.
- jump_valid (0x200) and branch_valid (branch_pc 0x40, offset 0x10) same cycle: next fetch 0x200; branch alone gives 0x54.
- Branch_pc 0xFFFFFFF8, offset 0x8, STEP 4: target wraps to 0x4.
- Reset low while queue holds 3 entries and request outstanding: all outputs at reset values immediately; restart at RESET_PC.
